// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Imported by the interface, the RAS and the top-level PC generator.
package pc_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_INC_BYTES = 4;

  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_HOLD   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JALR   = 3'd3,
    PC_TRAP   = 3'd4,
    PC_RAS    = 3'd5
  } pc_sel_e;

  // Only 32-bit aligned fetch targets are legal; either low bit set rejects the target.
  function automatic logic target_misaligned(input logic [1:0] lsbs);
    return |lsbs;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/RAS request bundle into the PC generator and the fetch PC/status coming back out.
// master drives requests (execute/trap side), slave is the PC generator.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            stall;
  logic            br_taken;
  logic [XLEN-1:0] br_base;
  logic [XLEN-1:0] br_imm;
  logic            jalr_valid;
  logic [XLEN-1:0] jalr_rs1;
  logic [XLEN-1:0] jalr_imm;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_data;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, br_taken, br_base, br_imm,
    output jalr_valid, jalr_rs1, jalr_imm,
    output trap_valid, trap_vec,
    output ras_push, ras_push_data, ras_pop,
    input  pc, pc_plus4, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  stall, br_taken, br_base, br_imm,
    input  jalr_valid, jalr_rs1, jalr_imm,
    input  trap_valid, trap_vec,
    input  ras_push, ras_push_data, ras_pop,
    output pc, pc_plus4, misaligned, ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating count.
// Overflow silently overwrites the oldest entry; push+pop together replaces the top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]      mem_q [RAS_DEPTH];
  logic                 push_eff, pop_eff;
  logic                 wr_en;
  logic [PTR_W-1:0]     wr_idx;
  logic [RAS_DEPTH-1:0] wr_sel;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top   = mem_q[ptr_q];

  always_comb begin
    push_eff = en & push;
    pop_eff  = en & pop & ~empty;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_idx   = ptr_q;
    if (push_eff && pop_eff) begin
      wr_en = 1'b1;
    end else if (push_eff) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_W'(1);
      ptr_d  = ptr_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_eff) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_idx == PTR_W'(gi));
    end
  endgenerate

  // Entries are not cleared on reset; a zero count already makes them unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (wr_sel[i]) begin
        mem_q[i] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with a prioritised next-PC mux (trap > jalr > branch > RAS > stall > +4)
// and a registered one-cycle flag for rejected misaligned redirect targets.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic [XLEN-1:0] jalr_sum, jalr_tgt, br_tgt, cand;
  logic            check_align;
  pc_sel_e         sel;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .en        (~bus.trap_valid),
    .push      (bus.ras_push),
    .pop       (bus.ras_pop),
    .push_data (bus.ras_push_data),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign jalr_sum = bus.jalr_rs1 + bus.jalr_imm;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign br_tgt   = bus.br_base + bus.br_imm;

  always_comb begin
    sel = PC_INC;
    if (bus.trap_valid) begin
      sel = PC_TRAP;
    end else if (bus.jalr_valid) begin
      sel = PC_JALR;
    end else if (bus.br_taken) begin
      sel = PC_BRANCH;
    end else if (bus.ras_pop && !ras_empty) begin
      sel = PC_RAS;
    end else if (bus.stall) begin
      sel = PC_HOLD;
    end
  end

  always_comb begin
    cand        = pc_q + XLEN'(PC_INC_BYTES);
    check_align = 1'b0;
    unique case (sel)
      PC_TRAP:   cand = bus.trap_vec;
      PC_JALR:   begin cand = jalr_tgt; check_align = 1'b1; end
      PC_BRANCH: begin cand = br_tgt;   check_align = 1'b1; end
      PC_RAS:    begin cand = ras_top;  check_align = 1'b1; end
      PC_HOLD:   cand = pc_q;
      default:   cand = pc_q + XLEN'(PC_INC_BYTES);
    endcase
  end

  // A rejected target leaves the PC where it is; the trap unit takes it from the flag.
  always_comb begin
    misaligned_d = check_align && target_misaligned(cand[1:0]);
    pc_d         = misaligned_d ? pc_q : cand;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_q + XLEN'(PC_INC_BYTES);
  assign bus.misaligned = misaligned_q;
  assign bus.ras_empty  = ras_empty;
  assign bus.ras_full   = ras_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: reset, stall, priority, misalignment and RAS scenarios.
module tb_pc_gen;

  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h8000_0000),
    .RAS_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%h mis=%b empty=%b full=%b", $time, bus.pc, bus.misaligned,
             bus.ras_empty, bus.ras_full);
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.br_taken = 0; bus.br_base = 0; bus.br_imm = 0;
    bus.jalr_valid = 0; bus.jalr_rs1 = 0; bus.jalr_imm = 0;
    bus.trap_valid = 0; bus.trap_vec = 0;
    bus.ras_push = 0; bus.ras_push_data = 0; bus.ras_pop = 0;
  endtask

  task automatic set_pc(input logic [31:0] addr);
    bus.trap_valid = 1; bus.trap_vec = addr;
    tick();
    bus.trap_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    checks++; if (bus.pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp 80000000", bus.pc); end
    checks++; if (bus.pc_plus4 !== 32'h8000_0004) begin errors++; $display("FAIL reset_pc_plus4 got %h exp 80000004", bus.pc_plus4); end
    checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", bus.misaligned); end
    checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras got empty=%b full=%b exp 1 0", bus.ras_empty, bus.ras_full); end
    rst = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.pc !== 32'h8000_0000 + 32'(4 * i)) begin
        errors++; $display("FAIL free_run%0d got %h exp %h", i, bus.pc, 32'h8000_0000 + 32'(4 * i));
      end
    end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL free_run_empty got %b exp 1", bus.ras_empty); end
  endtask

  task automatic test_stall();
    set_pc(32'h10);
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL stall_start got %h exp 10", bus.pc); end
    bus.stall = 1;
    tick();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL stall_hold got %h exp 10", bus.pc); end
    bus.br_taken = 1; bus.br_base = 32'h08; bus.br_imm = 32'h20;
    tick();
    checks++; if (bus.pc !== 32'h28) begin errors++; $display("FAIL stall_branch got %h exp 28", bus.pc); end
    clear_inputs();
    tick();
    checks++; if (bus.pc !== 32'h2C) begin errors++; $display("FAIL stall_release got %h exp 2c", bus.pc); end
  endtask

  task automatic test_priority();
    bus.ras_push = 1; bus.ras_push_data = 32'h60;
    tick();
    clear_inputs();
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL prio_push got empty=%b exp 0", bus.ras_empty); end
    bus.trap_valid = 1; bus.trap_vec = 32'h100;
    bus.jalr_valid = 1; bus.jalr_rs1 = 32'h41; bus.jalr_imm = 0;
    bus.br_taken = 1; bus.br_base = 0; bus.br_imm = 32'h8;
    bus.ras_pop = 1;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL prio_trap got %h exp 100", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL prio_ras_kept got empty=%b exp 0", bus.ras_empty); end
    bus.ras_pop = 1;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h60) begin errors++; $display("FAIL prio_pop got %h exp 60", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL prio_pop_empty got %b exp 1", bus.ras_empty); end
  endtask

  task automatic test_misaligned();
    set_pc(32'h300);
    bus.jalr_valid = 1; bus.jalr_rs1 = 32'h202; bus.jalr_imm = 0;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h300 || bus.misaligned !== 1'b1) begin errors++; $display("FAIL mis_jalr got pc=%h mis=%b exp 300 1", bus.pc, bus.misaligned); end
    tick();
    checks++; if (bus.pc !== 32'h304 || bus.misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse got pc=%h mis=%b exp 304 0", bus.pc, bus.misaligned); end
    bus.jalr_valid = 1; bus.jalr_rs1 = 32'h201;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h200 || bus.misaligned !== 1'b0) begin errors++; $display("FAIL jalr_lsb got pc=%h mis=%b exp 200 0", bus.pc, bus.misaligned); end
    bus.br_taken = 1; bus.br_base = 32'h10; bus.br_imm = 32'h2;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h200 || bus.misaligned !== 1'b1) begin errors++; $display("FAIL mis_branch got pc=%h mis=%b exp 200 1", bus.pc, bus.misaligned); end
    set_pc(32'h103);
    checks++; if (bus.pc !== 32'h103 || bus.misaligned !== 1'b0) begin errors++; $display("FAIL trap_unchecked got pc=%h mis=%b exp 103 0", bus.pc, bus.misaligned); end
    checks++; if (bus.pc_plus4 !== 32'h107) begin errors++; $display("FAIL pc_plus4 got %h exp 107", bus.pc_plus4); end
    bus.jalr_valid = 1; bus.jalr_rs1 = 32'hFFFF_FFF0; bus.jalr_imm = 32'h21;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL jalr_wrap got %h exp 10", bus.pc); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] push_vals [5];
    logic [31:0] pop_vals  [4];
    push_vals = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    pop_vals  = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};
    set_pc(32'h1000);
    for (int i = 0; i < 5; i++) begin
      bus.ras_push = 1; bus.ras_push_data = push_vals[i];
      tick();
      checks++;
      if (bus.ras_full !== (i >= 3)) begin
        errors++; $display("FAIL ras_full_push%0d got %b exp %b", i, bus.ras_full, (i >= 3));
      end
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.ras_pop = 1;
      tick();
      checks++;
      if (bus.pc !== pop_vals[i]) begin
        errors++; $display("FAIL ras_pop%0d got %h exp %h", i, bus.pc, pop_vals[i]);
      end
    end
    checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin errors++; $display("FAIL ras_drained got empty=%b full=%b exp 1 0", bus.ras_empty, bus.ras_full); end
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'hB4) begin errors++; $display("FAIL ras_pop_empty got %h exp b4", bus.pc); end
  endtask

  task automatic test_ras_simul();
    bus.ras_push = 1; bus.ras_push_data = 32'h40;
    tick();
    bus.ras_push_data = 32'h50; bus.ras_pop = 1;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL simul_redirect got %h exp 40", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b0) begin errors++; $display("FAIL simul_count got empty=%b exp 0", bus.ras_empty); end
    bus.ras_pop = 1;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h50) begin errors++; $display("FAIL simul_next_pop got %h exp 50", bus.pc); end
    checks++; if (bus.ras_empty !== 1'b1) begin errors++; $display("FAIL simul_drained got %b exp 1", bus.ras_empty); end
  endtask

  task automatic test_reset_mid();
    bus.ras_push = 1; bus.ras_push_data = 32'h77;
    tick();
    rst = 0; bus.ras_push_data = 32'h88;
    tick();
    checks++; if (bus.pc !== 32'h8000_0000 || bus.ras_empty !== 1'b1 || bus.misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_mid got pc=%h empty=%b mis=%b exp 80000000 1 0", bus.pc, bus.ras_empty, bus.misaligned);
    end
    rst = 1;
    clear_inputs();
    bus.ras_pop = 1;
    tick();
    clear_inputs();
    checks++; if (bus.pc !== 32'h8000_0004) begin errors++; $display("FAIL reset_mid_pop got %h exp 80000004", bus.pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 0;
    clear_inputs();
    test_reset();
    test_stall();
    test_priority();
    test_misaligned();
    test_ras_overflow();
    test_ras_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined core. It holds the fetch PC and selects the next PC from five sources: sequential increment, PC-relative branch, register-indirect jump (JALR), trap vector, and a return-address stack (RAS). It adds stall, registered misaligned-target detection and a circular RAS. It sits at the head of the fetch stage, and redirect information comes back from execute and the trap unit.

## Interface
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `RAS_DEPTH`, 4, number of RAS entries; must be a power of two, ≥2.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `stall` in 1: hold the PC; redirects override it.
- `br_taken` in 1: branch redirect from execute.
- `br_base` in XLEN: PC of the branch instruction.
- `br_imm` in XLEN: sign-extended branch offset.
- `jalr_valid` in 1: JALR redirect.
- `jalr_rs1` in XLEN: JALR base register value.
- `jalr_imm` in XLEN: JALR offset.
- `trap_valid` in 1: trap redirect.
- `trap_vec` in XLEN: trap target.
- `ras_push` in 1: push `ras_push_data` (call return address).
- `ras_push_data` in XLEN: value pushed onto the RAS.
- `ras_pop` in 1: return; redirect to the RAS top.
- `pc` out XLEN: current fetch PC.
- `pc_plus4` out XLEN: `pc + 4`.
- `misaligned` out 1: one-cycle pulse, previous redirect target rejected.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds `RAS_DEPTH` entries.

## Operation
- Next-PC priority, highest first:
  1. trap: `trap_vec`
  2. jalr: `(jalr_rs1 + jalr_imm) & ~1`
  3. branch: `br_base + br_imm`
  4. ras_pop: RAS top
  5. stall: hold `pc`
  6. otherwise: `pc + 4`
- All additions are modulo 2^XLEN; carry is discarded.
- Misalignment check applies to jalr, branch and RAS targets only. If `target[1] | target[0]` is set after the jalr LSB clear:
  - `pc` holds its value.
  - `misaligned` is 1 for the following cycle.
  - The trap unit responds.
- Trap targets are never checked.
- RAS: circular buffer with a top pointer and a count.
  - Push: write at top+1, advance the pointer, count += 1 saturating at `RAS_DEPTH`. On overflow the oldest entry is overwritten silently.
  - Pop: read the top, retreat the pointer, count -= 1.
  - Pop when empty: no PC redirect (falls through to the stall/increment choice), no pointer change.
  - Push and pop in the same cycle: the top entry is replaced by `ras_push_data`, the pointer and count are unchanged, and the redirect uses the old top.
- RAS push/pop bookkeeping happens regardless of `stall` or of a higher-priority redirect winning the PC mux. The exception is `trap_valid`: it blocks RAS updates that cycle.

## Timing
- Reset (`rst`=0 at a posedge): `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`, `misaligned`=0, RAS count=0, pointer=0, `ras_empty`=1, `ras_full`=0. Reset overrides all other inputs in that cycle. Reset mid-RAS-operation discards all entries.
- `pc` is registered. A redirect presented in cycle N appears on `pc` after the posedge ending cycle N, so redirect latency is one cycle.
- `pc_plus4` is combinational from `pc`.
- `misaligned` is registered. It rises one cycle after the offending request and lasts exactly one cycle unless re-triggered.
- `ras_empty`/`ras_full` are derived from the registered count and reflect updates one cycle after the push/pop.
- A stall held for K cycles keeps `pc` constant for K cycles. Release resumes with `pc + 4`.

## Structure
- `pc_pkg`: `pc_sel_e` enum (`PC_INC`, `PC_HOLD`, `PC_BRANCH`, `PC_JALR`, `PC_TRAP`, `PC_RAS`), `XLEN_DEFAULT`, `PC_INC_BYTES = 4`.
- Sub-module `pc_ras`: parametrised by `XLEN` and `RAS_DEPTH`. Owns storage, pointer, count and the simultaneous push/pop rule, and exposes `top`, `empty` and `full`.
- `pc_gen` contains the priority mux, adders, misalignment check and the PC register.

## Test plan
- Reset with `RESET_PC`=32'h8000_0000, then 3 free cycles → `pc` = 8000_0000, 8000_0004, 8000_0008, 8000_000C; `ras_empty`=1.
- `stall`=1 for 2 cycles at `pc`=0x10, with `br_taken`, `br_base`=0x08, `br_imm`=0x20 in the second stall cycle → `pc`=0x10, 0x10, then 0x28.
- `trap_valid`, `jalr_valid` and `br_taken` all asserted; `trap_vec`=0x100, `jalr_rs1`=0x41, `jalr_imm`=0 → next `pc`=0x100, RAS unchanged.
- JALR with `jalr_rs1`=0x202, `jalr_imm`=0 → `pc` holds; `misaligned`=1 for exactly one cycle. `jalr_rs1`=0x201 → `pc`=0x200, no flag.
- With `RAS_DEPTH`=4, push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0, then 5 pops → redirects to E0, D0, C0, B0. The fifth pop is empty: no redirect, `pc` increments. `ras_full` sets after the 4th push.
- With top=0x40, simultaneous push(0x50) and pop → redirect to 0x40; the next pop redirects to 0x50; the count is unchanged by the simultaneous cycle.
